// File: rtl/result_tx_formatter.sv
// Formats a signed 8-bit result as ASCII decimal terminated by CR and
// sends it as UART 8N1, LSB first, frames back-to-back.
module result_tx_formatter #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] RESULT,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // The byte-advance decision is taken in the last STOP cycle, so no
  // separate state is needed for it.
  typedef enum logic [2:0] {IDLE, LOAD, START_BIT, DATA, STOP, FINISH} state_t;

  state_t           state;
  logic [7:0]       value;
  logic [7:0]       byte_buf [0:4];
  logic [2:0]       byte_cnt;
  logic [2:0]       byte_ptr;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic             tx_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [7:0] mag;
  logic [7:0] rem;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] units;
  logic [7:0] ld_buf [0:4];
  logic [2:0] ld_cnt;

  always_comb begin
    mag = value[7] ? (8'd0 - value) : value;
    if (mag >= 8'd200) begin
      hundreds = 4'd2;
      rem      = mag - 8'd200;
    end else if (mag >= 8'd100) begin
      hundreds = 4'd1;
      rem      = mag - 8'd100;
    end else begin
      hundreds = 4'd0;
      rem      = mag;
    end
    tens  = 4'(rem / 8'd10);
    units = 4'(rem % 8'd10);

    for (int i = 0; i < 5; i++) ld_buf[i] = 8'h00;
    ld_cnt = 3'd0;
    if (value[7]) begin
      ld_buf[ld_cnt] = 8'h2D;
      ld_cnt = ld_cnt + 3'd1;
    end
    if (hundreds != 4'd0) begin
      ld_buf[ld_cnt] = {4'h3, hundreds};
      ld_cnt = ld_cnt + 3'd1;
    end
    if (hundreds != 4'd0 || tens != 4'd0) begin
      ld_buf[ld_cnt] = {4'h3, tens};
      ld_cnt = ld_cnt + 3'd1;
    end
    ld_buf[ld_cnt] = {4'h3, units};
    ld_cnt = ld_cnt + 3'd1;
    ld_buf[ld_cnt] = 8'h0D;
    ld_cnt = ld_cnt + 3'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      value    <= 8'd0;
      byte_cnt <= 3'd0;
      byte_ptr <= 3'd0;
      bit_idx  <= 3'd0;
      baud_cnt <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      for (int i = 0; i < 5; i++) byte_buf[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          tx_reg   <= 1'b1;
          done_reg <= 1'b0;
          if (START) begin
            value    <= RESULT;
            busy_reg <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          for (int i = 0; i < 5; i++) byte_buf[i] <= ld_buf[i];
          byte_cnt <= ld_cnt;
          byte_ptr <= 3'd0;
          baud_cnt <= '0;
          tx_reg   <= 1'b0;
          state    <= START_BIT;
        end
        START_BIT: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx_reg   <= byte_buf[byte_ptr][0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_reg <= 1'b1;
              state  <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_reg  <= byte_buf[byte_ptr][3'(bit_idx + 3'd1)];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if ((byte_ptr + 3'd1) < byte_cnt) begin
              byte_ptr <= byte_ptr + 3'd1;
              tx_reg   <= 1'b0;
              state    <= START_BIT;
            end else begin
              tx_reg   <= 1'b1;
              busy_reg <= 1'b0;
              done_reg <= 1'b1;
              state    <= FINISH;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        FINISH: begin
          done_reg <= 1'b0;
          tx_reg   <= 1'b1;
          // BUSY is already low here, so a request in this cycle is honoured.
          if (START) begin
            value    <= RESULT;
            busy_reg <= 1'b1;
            state    <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign TX   = tx_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;

endmodule
